// File: rtl/sd_writer.sv
// sd_writer: byte-serial store engine for the SD byte memory, 1-4 bytes little-endian per request.
// Define SD_WRITER_READBACK_EN to verify each written byte through DM before moving on.
module sd_writer #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  output logic              ready,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [31:0]       DATA,
  input  logic [2:0]        BYTE,
  output logic [ADDR_W-1:0] AM,
  output logic [7:0]        DM_,
  output logic              EW,
  input  logic [7:0]        DM,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;
  logic [1:0]        r_st;
  logic [ADDR_W-1:0] r_a;
  logic [31:0]       r_d;
  logic [2:0]        r_n;
  logic [1:0]        r_i;
  logic [ADDR_W-1:0] r_am;
  logic [7:0]        r_dm;
  logic              r_ew;
  logic              r_done;
  logic              r_err;
  logic [ADDR_W:0]   w_sum;
  logic              w_bad;
  logic              w_last;
  logic [1:0]        w_ni;
  // one extra bit so ADDR+BYTE near the top of the address space cannot wrap into range
  assign w_sum  = {1'b0, ADDR} + (ADDR_W+1)'(BYTE);
  assign w_bad  = (BYTE == 3'd0) || (BYTE > 3'd4) || (w_sum > (ADDR_W+1)'(MEM_DEPTH));
  assign w_ni   = r_i + 2'd1;
  assign w_last = ({1'b0, r_i} == r_n - 3'd1);
  assign ready  = (r_st == S_IDLE);
  assign busy   = (r_st != S_IDLE);
  assign AM     = r_am;
  assign DM_    = r_dm;
  assign EW     = r_ew;
  assign done   = r_done;
  assign err    = r_err;
`ifndef SD_WRITER_READBACK_EN
  logic w_unused_dm;
  assign w_unused_dm = ^DM;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st   <= S_IDLE;
      r_a    <= '0;
      r_d    <= '0;
      r_n    <= '0;
      r_i    <= '0;
      r_am   <= '0;
      r_dm   <= '0;
      r_ew   <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_st)
        S_IDLE: if (req) begin
          r_a <= ADDR;
          r_d <= DATA;
          r_n <= BYTE;
          r_i <= 2'd0;
          if (w_bad) begin
            r_err <= 1'b1;
            r_st  <= S_FIN;
          end else begin
            r_am <= ADDR;
            r_dm <= DATA[7:0];
            r_ew <= 1'b1;
            r_st <= S_WRITE;
          end
        end
`ifdef SD_WRITER_READBACK_EN
        S_WRITE: begin
          r_ew <= 1'b0;
          r_st <= S_CHECK;
        end
        S_CHECK: if (DM != r_dm) begin
          r_err <= 1'b1;
          r_st  <= S_FIN;
        end else if (w_last) begin
          r_done <= 1'b1;
          r_st   <= S_FIN;
        end else begin
          r_i  <= w_ni;
          r_am <= r_a + ADDR_W'(w_ni);
          r_dm <= r_d[{w_ni, 3'b000} +: 8];
          r_ew <= 1'b1;
          r_st <= S_WRITE;
        end
`else
        S_WRITE: if (w_last) begin
          r_ew   <= 1'b0;
          r_done <= 1'b1;
          r_st   <= S_FIN;
        end else begin
          r_i  <= w_ni;
          r_am <= r_a + ADDR_W'(w_ni);
          r_dm <= r_d[{w_ni, 3'b000} +: 8];
        end
`endif
        default: r_st <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/sd_writer.md
# sd_writer

Byte-serial write engine for the SD data memory: it is the write-side counterpart of the SD byte-read port. It accepts one word-store request of 1–4 bytes with a valid/ready handshake, checks it, and drives the memory write port (`AM`, `DM_`, `EW`) one byte per cycle, little-endian. It sits between the datapath store logic and the SD byte memory, and reports completion with a `done` pulse and rejection or abort with an `err` pulse.

## Interface
- `MEM_DEPTH`, 256: number of bytes in the SD memory; the legal address range is 0..MEM_DEPTH-1.
- `ADDR_W`, 32: address width, matching `AM`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  1  request valid.
- `ready`  out  1  high only in IDLE; a request is accepted on a rising edge where `req && ready`.
- `ADDR`  in  ADDR_W  start byte address, sampled at accept.
- `DATA`  in  32  store data, sampled at accept.
- `BYTE`  in  3  byte count, sampled at accept; legal values are 1..4.
- `AM`  out  ADDR_W  memory byte address.
- `DM_`  out  8  memory write data.
- `EW`  out  1  memory write enable; the memory writes `DM_` to `mem[AM]` in any cycle where `EW`=1.
- `DM`  in  8  memory read data for `AM`; used only when SD_WRITER_READBACK_EN is defined.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a request completes successfully.
- `err`  out  1  one-cycle pulse when a request is rejected or aborted.

## Operation
- States: IDLE, WRITE, CHECK (readback build only), FIN.
- Accept in IDLE: the block registers `ADDR`, `DATA` and `BYTE` into `a_r`, `d_r` and `n_r`, and clears the byte index `i` to 0.
- Request validity check at accept:
  - The request is illegal if `BYTE`==0 or `BYTE`>4.
  - The request is illegal if `ADDR`+`BYTE` > MEM_DEPTH. This sum is computed ADDR_W+1 bits wide, so it cannot wrap.
  - An illegal request goes to FIN with the error flag set. No `EW` is issued.
- WRITE drives:
  - `AM`=`a_r`+`i` (ADDR_W bits);
  - `DM_`=`d_r[8i+7:8i]`, i.e. byte 0 is `DATA[7:0]` at `ADDR`;
  - `EW`=1.
- After WRITE, in the base build: if `i`==`n_r`-1, go to FIN (success); otherwise increment `i` and stay in WRITE.
- FIN (one cycle): pulse `done` on success or `err` on failure, then return to IDLE.
- `AM` and `DM_` hold their last values in IDLE and FIN. `EW` is 0 outside WRITE.
- `req` while busy is ignored; it is not queued.
- The request inputs may change freely after accept.

## Timing
- Reset values: `AM`=0, `DM_`=0, `EW`=0, `busy`=0, `done`=0, `err`=0, `ready`=1.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronously). The transfer is abandoned, and neither `done` nor `err` is pulsed.
- Request accepted at edge N, base build:
  - `EW` is high in cycles N+1 through N+k, where k=`BYTE`.
  - `done`=1 in cycle N+k+1.
  - `ready`=1 again from cycle N+k+2.
  - Accept-to-accept throughput is k+2 cycles.
- Illegal request accepted at edge N: `err`=1 in cycle N+1, and `ready`=1 from cycle N+2.
- `done` and `err` are never high in the same cycle.
- All outputs are registered; none is combinational from the inputs.

## Configuration
- Macro `SD_WRITER_READBACK_EN`.
- Defined: after each WRITE the block enters CHECK for one cycle:
  - `AM` is held, `EW`=0, and the block compares `DM` against the byte just written.
  - Match on the last byte: go to FIN and pulse `done`.
  - Match otherwise: increment `i` and return to WRITE.
  - Mismatch: go to FIN and pulse `err`. The remaining bytes are not written.
  - Each byte costs 2 cycles: `done` arrives in cycle N+2k+1 and `ready` returns in cycle N+2k+2.
- Not defined: there is no CHECK state, the `DM` input is unused, and the timing is as given under Timing.

## Test plan
- Full-word store: `ADDR`=0x10, `DATA`=0x6C6C6548, `BYTE`=4. Require `EW` high for 4 cycles with (`AM`,`DM_`) = (0x10,0x48), (0x11,0x65), (0x12,0x6C), (0x13,0x6C), then `done` 1 cycle later, and memory dump matches.
- Single byte: `ADDR`=0xFF, `BYTE`=1, `DATA`=0xA5. Require exactly one `EW` at `AM`=0xFF with `DM_`=0xA5, `done` at N+2, and no `err`.
- Illegal requests:
  - `BYTE`=0 requires `err` at N+1 and zero `EW` cycles.
  - `BYTE`=5 requires the same.
  - `ADDR`=0xFE with `BYTE`=4 (MEM_DEPTH=256) requires `err` and no memory change.
- Reset mid-transfer: assert `rst_n`=0 during the second WRITE cycle of a 4-byte store. Require `EW`=0 immediately, memory holds only byte 0, no `done`/`err` pulse, and `ready`=1 after release.
- Back-to-back requests: hold `req`=1 with new data. Require the second accept exactly at the first edge where `ready`=1 (k+2 cycles after the first accept), and no request accepted while `busy`=1.
- Readback build: force `DM` to mismatch on byte 2 of a 4-byte store. Require `err` pulse, bytes 0–1 written, bytes 2–3 untouched beyond the single failed write, and no `done`.
